// File: rtl/snax_gemm_ctrl_pkg.sv
// Shared constants for the SNAX GEMM job sequencer: FSM encoding, CSR word
// indices, status bit positions and control flag positions.
package snax_gemm_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StLaunch = 2'd1;
    localparam state_t StRun    = 2'd2;
    localparam state_t StDone   = 2'd3;

    // RW CSR word indices
    localparam int unsigned CsrM    = 0;
    localparam int unsigned CsrK    = 1;
    localparam int unsigned CsrN    = 2;
    localparam int unsigned CsrSub  = 3;
    localparam int unsigned CsrCtrl = 4;

    // RO CSR word indices
    localparam int unsigned RoStatus = 0;
    localparam int unsigned RoPerf   = 1;

    // Status word bit positions
    localparam int unsigned StatBusy = 0;
    localparam int unsigned StatPend = 1;
    localparam int unsigned StatDone = 2;
    localparam int unsigned StatErrz = 3;
    localparam int unsigned StatTmo  = 4;

    // Control word flag positions
    localparam int unsigned CtrlClr = 0;

endpackage

// File: rtl/snax_gemm_ctrl_cnt.sv
// Loadable down counter; load has priority over decrement, no saturation.
module snax_gemm_ctrl_cnt #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o,
    output logic             is_one_o
);

    logic [Width-1:0] cnt_q;

    // Count register: load wins over decrement
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign cnt_o    = cnt_q;
    assign is_one_o = (cnt_q == Width'(1));

endmodule

// File: rtl/snax_gemm_ctrl.sv
// CSR-driven GEMM job sequencer: one-deep shadow job buffer, launch handshake,
// C-beat completion tracking, status/perf reporting and a done pulse.
// Optional watchdog enabled by defining SNAX_GEMM_CTRL_TIMEOUT_EN.
module snax_gemm_ctrl
    import snax_gemm_ctrl_pkg::*;
#(
    parameter int unsigned RegRWCount    = 5,
    parameter int unsigned RegROCount    = 2,
    parameter int unsigned RegDataWidth  = 32,
    parameter int unsigned DimWidth      = 16,
    parameter int unsigned TimeoutCycles = 4096
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i,
    input  logic                             csr_reg_set_valid_i,
    output logic                             csr_reg_set_ready_o,
    output logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o,
    output logic                             gemm_ctrl_valid_o,
    input  logic                             gemm_ctrl_ready_i,
    output logic [RegDataWidth-1:0]          gemm_m_o,
    output logic [RegDataWidth-1:0]          gemm_k_o,
    output logic [RegDataWidth-1:0]          gemm_n_o,
    output logic [RegDataWidth-1:0]          gemm_sub_const_o,
    input  logic                             c_valid_i,
    input  logic                             c_ready_i,
    output logic                             done_o
);

    localparam int unsigned RemWidth = 2 * DimWidth;

    state_t state_q, state_d;
    logic shadow_valid_q, shadow_valid_d;
    logic [DimWidth-1:0] sh_m_q, sh_k_q, sh_n_q, act_m_q, act_k_q, act_n_q;
    logic [RegDataWidth-1:0] sh_sub_q, act_sub_q, perf_q, perf_d, status;
    logic done_seen_q, err_zero_q;

    logic [DimWidth-1:0] in_m, in_k, in_n;
    logic [RegDataWidth-1:0] in_sub, in_ctrl;
    logic accept, zero_dim, clr, fire, launch_entry, last_beat, timeout, tmo_flag;
    logic [RemWidth-1:0] rem_cnt;
    logic rem_is_one, unused_sig;

    assign in_m    = csr_reg_set_i[CsrM*RegDataWidth +: DimWidth];
    assign in_k    = csr_reg_set_i[CsrK*RegDataWidth +: DimWidth];
    assign in_n    = csr_reg_set_i[CsrN*RegDataWidth +: DimWidth];
    assign in_sub  = csr_reg_set_i[CsrSub*RegDataWidth +: RegDataWidth];
    assign in_ctrl = csr_reg_set_i[CsrCtrl*RegDataWidth +: RegDataWidth];

    assign csr_reg_set_ready_o = ~shadow_valid_q;
    assign accept   = csr_reg_set_valid_i & ~shadow_valid_q;
    assign zero_dim = (in_m == '0) | (in_k == '0) | (in_n == '0);
    assign clr      = in_ctrl[CtrlClr];
    assign fire     = c_valid_i & c_ready_i;
    assign last_beat = (state_q == StRun) & fire & rem_is_one;

    // Outstanding C beats for the active job
    snax_gemm_ctrl_cnt #(
        .Width(RemWidth)
    ) u_rem (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     ((state_q == StLaunch) && gemm_ctrl_ready_i),
        .load_val_i (RemWidth'(act_m_q) * RemWidth'(act_n_q)),
        .dec_i      ((state_q == StRun) && fire),
        .cnt_o      (rem_cnt),
        .is_one_o   (rem_is_one)
    );

`ifdef SNAX_GEMM_CTRL_TIMEOUT_EN
    localparam int unsigned WdWidth = $clog2(TimeoutCycles + 1);
    logic [WdWidth-1:0] wd_cnt;
    logic wd_is_one, tmo_q, unused_wd;

    // Watchdog: re-armed at launch and on every C fire, counts idle RUN cycles
    snax_gemm_ctrl_cnt #(
        .Width(WdWidth)
    ) u_wd (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (((state_q == StLaunch) && gemm_ctrl_ready_i) || ((state_q == StRun) && fire)),
        .load_val_i (WdWidth'(TimeoutCycles)),
        .dec_i      ((state_q == StRun) && !fire),
        .cnt_o      (wd_cnt),
        .is_one_o   (wd_is_one)
    );

    assign timeout   = (state_q == StRun) && !fire && wd_is_one;
    assign unused_wd = ^wd_cnt;

    // Sticky timeout flag; a new timeout wins over a simultaneous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= 1'b0;
        end else if (timeout) begin
            tmo_q <= 1'b1;
        end else if (accept && clr) begin
            tmo_q <= 1'b0;
        end
    end

    assign tmo_flag = tmo_q;
`else
    localparam int unsigned unused_tmo_cycles = TimeoutCycles;
    assign timeout  = 1'b0;
    assign tmo_flag = 1'b0;
`endif

    // Next-state logic for the job FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (shadow_valid_q) state_d = StLaunch;
            StLaunch: if (gemm_ctrl_ready_i) state_d = StRun;
            StRun:    if (last_beat || timeout) state_d = StDone;
            StDone:   state_d = shadow_valid_q ? StLaunch : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign launch_entry = (state_d == StLaunch) && (state_q != StLaunch);

    // Shadow occupancy and perf counter next state
    always_comb begin
        shadow_valid_d = shadow_valid_q;
        if (launch_entry) shadow_valid_d = 1'b0;
        // accept needs an empty shadow, launch needs a full one: never both
        if (accept && !zero_dim) shadow_valid_d = 1'b1;

        perf_d = perf_q;
        if (launch_entry) begin
            perf_d = '0;
        end else if (((state_q == StLaunch) || (state_q == StRun)) && (perf_q != '1)) begin
            perf_d = perf_q + RegDataWidth'(1);
        end
    end

    // State, shadow/active job registers and sticky status bits
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            shadow_valid_q <= 1'b0;
            sh_m_q         <= '0;
            sh_k_q         <= '0;
            sh_n_q         <= '0;
            sh_sub_q       <= '0;
            act_m_q        <= '0;
            act_k_q        <= '0;
            act_n_q        <= '0;
            act_sub_q      <= '0;
            perf_q         <= '0;
            done_seen_q    <= 1'b0;
            err_zero_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_valid_q <= shadow_valid_d;
            perf_q         <= perf_d;
            if (accept && !zero_dim) begin
                sh_m_q   <= in_m;
                sh_k_q   <= in_k;
                sh_n_q   <= in_n;
                sh_sub_q <= in_sub;
            end
            if (launch_entry) begin
                act_m_q   <= sh_m_q;
                act_k_q   <= sh_k_q;
                act_n_q   <= sh_n_q;
                act_sub_q <= sh_sub_q;
            end
            if (state_q == StDone) begin
                done_seen_q <= 1'b1;
            end else if (accept) begin
                done_seen_q <= 1'b0;
            end
            if (accept && zero_dim) begin
                err_zero_q <= 1'b1;
            end else if (accept && clr) begin
                err_zero_q <= 1'b0;
            end
        end
    end

    // Status word and RO CSR packing
    always_comb begin
        status           = '0;
        status[StatBusy] = (state_q != StIdle);
        status[StatPend] = shadow_valid_q;
        status[StatDone] = done_seen_q;
        status[StatErrz] = err_zero_q;
        status[StatTmo]  = tmo_flag;

        csr_reg_ro_set_o = '0;
        csr_reg_ro_set_o[RoStatus*RegDataWidth +: RegDataWidth] = status;
        csr_reg_ro_set_o[RoPerf*RegDataWidth +: RegDataWidth]   = perf_q;
    end

    assign gemm_ctrl_valid_o = (state_q == StLaunch);
    assign done_o            = (state_q == StDone);
    assign gemm_m_o          = RegDataWidth'(act_m_q);
    assign gemm_k_o          = RegDataWidth'(act_k_q);
    assign gemm_n_o          = RegDataWidth'(act_n_q);
    assign gemm_sub_const_o  = act_sub_q;

    // Ignored CSR bits (dim MSBs, reserved ctrl flags) and the raw remaining count
    assign unused_sig = ^{csr_reg_set_i, rem_cnt};

endmodule

// File: tb/tb_snax_gemm_ctrl.sv
// Self-checking bench for snax_gemm_ctrl: directed corner sequences, a
// table of job vectors and randomized jobs checked against a job-level model.
module tb_snax_gemm_ctrl;

    localparam int unsigned RW = 5, RO = 2, DW = 32, DimW = 16, Tmo = 16;

    logic clk, rst;
    logic [RW*DW-1:0] csr_reg_set_i;
    logic csr_reg_set_valid_i, csr_reg_set_ready_o;
    logic [RO*DW-1:0] csr_reg_ro_set_o;
    logic gemm_ctrl_valid_o, gemm_ctrl_ready_i;
    logic [DW-1:0] gemm_m_o, gemm_k_o, gemm_n_o, gemm_sub_const_o;
    logic c_valid_i, c_ready_i, done_o;
    logic [31:0] st, perf;

    int n_pass = 0;
    int n_total = 0;
    bit m_errz = 0;
    bit m_done_seen = 0;

    typedef struct {
        logic [31:0] m, k, n, sub, ctrl;
        bit exp_launch;
        bit exp_errz;
    } vec_t;

    vec_t vecs[7];

    assign st   = csr_reg_ro_set_o[31:0];
    assign perf = csr_reg_ro_set_o[63:32];

    snax_gemm_ctrl #(
        .RegRWCount(RW), .RegROCount(RO), .RegDataWidth(DW), .DimWidth(DimW),
        .TimeoutCycles(Tmo)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .csr_reg_set_i       (csr_reg_set_i),
        .csr_reg_set_valid_i (csr_reg_set_valid_i),
        .csr_reg_set_ready_o (csr_reg_set_ready_o),
        .csr_reg_ro_set_o    (csr_reg_ro_set_o),
        .gemm_ctrl_valid_o   (gemm_ctrl_valid_o),
        .gemm_ctrl_ready_i   (gemm_ctrl_ready_i),
        .gemm_m_o            (gemm_m_o),
        .gemm_k_o            (gemm_k_o),
        .gemm_n_o            (gemm_n_o),
        .gemm_sub_const_o    (gemm_sub_const_o),
        .c_valid_i           (c_valid_i),
        .c_ready_i           (c_ready_i),
        .done_o              (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a job on the CSR port, wait for the handshake edge, update sticky model
    task automatic write_job(input logic [31:0] m, k, n, s, c);
        int g;
        bit zero;
        g = 0;
        csr_reg_set_i = {c, s, n, k, m};
        csr_reg_set_valid_i = 1'b1;
        while (!csr_reg_set_ready_o && g < 200) begin
            step();
            g++;
        end
        if (g >= 200) begin
            n_total++;
            $display("FAIL csr_ready_wait: ready never rose, expected within 200 cycles");
        end
        step();
        csr_reg_set_valid_i = 1'b0;
        zero = (m[15:0] == 16'h0) || (k[15:0] == 16'h0) || (n[15:0] == 16'h0);
        m_done_seen = 0;
        if (c[0]) m_errz = 0;
        if (zero) m_errz = 1;
        check("accept_status", st[3:1], {29'h0, m_errz, 1'b0, !zero});
    endtask

    // Drive one job from launch to done and check it against the job-level model
    task automatic run_job(input logic [31:0] mw, kw, nw, sw, input int rdy_dly,
                           input int c_pct);
        int unsigned em, ek, en, beats, fires, cyc, g;
        bit early, stable;
        em = {16'h0, mw[15:0]};
        ek = {16'h0, kw[15:0]};
        en = {16'h0, nw[15:0]};
        beats = em * en;
        g = 0;
        while (!gemm_ctrl_valid_o && g < 10) begin
            step();
            g++;
        end
        check("launch_valid", gemm_ctrl_valid_o, 1);
        check("launch_dims", {gemm_m_o[7:0], gemm_k_o[7:0], gemm_n_o[7:0]},
              {8'h0, em[7:0], ek[7:0], en[7:0]});
        check("launch_sub", gemm_sub_const_o, sw);
        cyc = 0;
        stable = 1;
        for (int i = 0; i <= rdy_dly; i++) begin
            gemm_ctrl_ready_i = (i == rdy_dly);
            // C traffic before acceptance must not count
            c_valid_i = 1'($urandom_range(1));
            c_ready_i = 1'($urandom_range(1));
            if (!gemm_ctrl_valid_o || gemm_m_o != em || gemm_k_o != ek || gemm_n_o != en ||
                gemm_sub_const_o != sw) stable = 0;
            step();
            cyc++;
        end
        gemm_ctrl_ready_i = 1'b0;
        check("launch_stable", stable, 1);
        fires = 0;
        early = 0;
        g = 0;
        while (fires < beats && g < 2000) begin
            c_valid_i = ($urandom_range(99) < c_pct);
            c_ready_i = ($urandom_range(99) < c_pct);
            if (done_o) early = 1;
            if (c_valid_i && c_ready_i) fires++;
            step();
            cyc++;
            g++;
        end
        c_valid_i = 1'b0;
        c_ready_i = 1'b0;
        check("run_fires", fires, beats);
        check("no_early_done", early, 0);
        check("done_pulse", done_o, 1);
        check("perf_cycles", perf, cyc);
        m_done_seen = 1;
        step();
        check("done_one_cycle", done_o, 0);
        check("sticky_bits", st[3:2], {30'h0, m_errz, m_done_seen});
    endtask

    initial begin
        int cnt;
        bit flag;
        logic [31:0] rm, rk, rn, rs;

        vecs[0] = '{m: 2, k: 3, n: 2, sub: 32'h11, ctrl: 0, exp_launch: 1, exp_errz: 0};
        vecs[1] = '{m: 0, k: 4, n: 4, sub: 0, ctrl: 0, exp_launch: 0, exp_errz: 1};
        vecs[2] = '{m: 3, k: 3, n: 3, sub: 0, ctrl: 0, exp_launch: 1, exp_errz: 1};
        vecs[3] = '{m: 1, k: 2, n: 1, sub: 32'h7F, ctrl: 1, exp_launch: 1, exp_errz: 0};
        vecs[4] = '{m: 32'h0001_0002, k: 5, n: 32'hABCD_0001, sub: 32'hDEAD_BEEF, ctrl: 0,
                    exp_launch: 1, exp_errz: 0};
        vecs[5] = '{m: 4, k: 32'h0001_0000, n: 1, sub: 0, ctrl: 1, exp_launch: 0, exp_errz: 1};
        vecs[6] = '{m: 1, k: 1, n: 1, sub: 3, ctrl: 1, exp_launch: 1, exp_errz: 0};

        rst = 1'b1;
        csr_reg_set_i = '0;
        csr_reg_set_valid_i = 1'b0;
        gemm_ctrl_ready_i = 1'b0;
        c_valid_i = 1'b0;
        c_ready_i = 1'b0;
        step();
        step();
        check("rst_ready", csr_reg_set_ready_o, 1);
        check("rst_valid", gemm_ctrl_valid_o, 0);
        check("rst_dims", gemm_m_o | gemm_k_o | gemm_n_o | gemm_sub_const_o, 0);
        check("rst_done", done_o, 0);
        check("rst_status", st, 0);
        check("rst_perf", perf, 0);
        rst = 1'b0;
        step();

        // Single job: launch latency, then 4 beats at full rate
        write_job(2, 3, 2, 5, 0);
        check("lat_valid_t1", gemm_ctrl_valid_o, 0);
        check("lat_ready_low", csr_reg_set_ready_o, 0);
        step();
        check("lat_valid_t2", gemm_ctrl_valid_o, 1);
        check("lat_ready_back", csr_reg_set_ready_o, 1);
        run_job(2, 3, 2, 5, 0, 100);
        check("single_idle", st[1:0], 0);

        // Back-to-back: job B queued while job A runs
        write_job(2, 1, 2, 9, 0);
        step();
        gemm_ctrl_ready_i = 1'b1;
        step();
        gemm_ctrl_ready_i = 1'b0;
        write_job(1, 1, 1, 32'h55, 0);
        check("b2b_ready_low", csr_reg_set_ready_o, 0);
        c_valid_i = 1'b1;
        c_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        c_valid_i = 1'b0;
        c_ready_i = 1'b0;
        check("b2b_done_a", done_o, 1);
        m_done_seen = 1;
        check("b2b_pend_in_done", st[1], 1);
        step();
        check("b2b_relaunch", gemm_ctrl_valid_o, 1);
        check("b2b_dims_b", {gemm_m_o[7:0], gemm_n_o[7:0], gemm_sub_const_o[7:0]}, 32'h01_01_55);
        check("b2b_ready_back", csr_reg_set_ready_o, 1);
        run_job(1, 1, 1, 32'h55, 2, 80);

        // Backpressure on launch and throttled C beats
        write_job(3, 2, 2, 32'hCAFE, 0);
        run_job(3, 2, 2, 32'hCAFE, 5, 50);

        // Zero dimension: dropped job, sticky error, cleared by ctrl flag
        write_job(2, 2, 0, 0, 0);
        check("zero_ready", csr_reg_set_ready_o, 1);
        flag = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (gemm_ctrl_valid_o) flag = 1;
        end
        check("zero_no_launch", flag, 0);
        check("zero_errz", st[3], 1);
        write_job(1, 1, 1, 0, 1);
        check("zero_errz_clr", st[3], 0);
        run_job(1, 1, 1, 0, 0, 100);

        // Table-driven job vectors
        foreach (vecs[i]) begin
            write_job(vecs[i].m, vecs[i].k, vecs[i].n, vecs[i].sub, vecs[i].ctrl);
            check("tbl_errz", st[3], vecs[i].exp_errz);
            check("tbl_pend", st[1] | gemm_ctrl_valid_o, vecs[i].exp_launch);
            if (vecs[i].exp_launch) run_job(vecs[i].m, vecs[i].k, vecs[i].n, vecs[i].sub, 1, 90);
        end

        // Randomized jobs
        for (int i = 0; i < 8; i++) begin
            rm = $urandom_range(1, 4) | ($urandom_range(1) ? 32'h5A5A_0000 : 32'h0);
            rk = $urandom_range(1, 9);
            rn = $urandom_range(1, 4);
            rs = $urandom;
            write_job(rm, rk, rn, rs, 32'($urandom_range(1)));
            run_job(rm, rk, rn, rs, $urandom_range(0, 4), $urandom_range(75, 100));
        end

        // Asynchronous reset with three beats outstanding
        write_job(2, 1, 2, 1, 0);
        step();
        gemm_ctrl_ready_i = 1'b1;
        step();
        gemm_ctrl_ready_i = 1'b0;
        c_valid_i = 1'b1;
        c_ready_i = 1'b1;
        step();
        c_valid_i = 1'b0;
        c_ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", gemm_ctrl_valid_o, 0);
        check("arst_ready", csr_reg_set_ready_o, 1);
        check("arst_ro", csr_reg_ro_set_o[31:0] | csr_reg_ro_set_o[63:32], 0);
        check("arst_done", done_o, 0);
        check("arst_dims", gemm_m_o, 0);
        m_errz = 0;
        m_done_seen = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flag = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done_o || gemm_ctrl_valid_o) flag = 1;
        end
        check("arst_quiet", flag, 0);

`ifdef SNAX_GEMM_CTRL_TIMEOUT_EN
        // Watchdog: no C traffic after launch
        write_job(1, 1, 1, 0, 1);
        step();
        gemm_ctrl_ready_i = 1'b1;
        step();
        gemm_ctrl_ready_i = 1'b0;
        cnt = 0;
        while (!done_o && cnt < 100) begin
            step();
            cnt++;
        end
        check("tmo_run_cycles", cnt, Tmo);
        check("tmo_done", done_o, 1);
        check("tmo_status", st[4], 1);
`else
        cnt = 0;
        check("tmo_bit_absent", st[4], 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/snax_gemm_ctrl.md
Name: snax_gemm_ctrl

Overview:
- CSR-driven job sequencer placed between the SNAX CSR manager and the GEMM core's control port.
- Buffers one pending job (M, K, N, subtraction constant) in a shadow register and launches it on the GEMM ctrl handshake.
- Counts C-output beats to detect job completion and reports status, a per-job cycle counter and a done pulse.
- Lets software queue job n+1 while job n runs.

Parameters:
- RegRWCount, 5, number of CSR RW words (0:M, 1:K, 2:N, 3:sub_const, 4:ctrl flags).
- RegROCount, 2, number of CSR RO words (0:status, 1:perf counter).
- RegDataWidth, 32, CSR word width.
- DimWidth, 16, LSBs of M/K/N used; upper bits ignored.
- TimeoutCycles, 4096, watchdog limit (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- csr_reg_set_i  in  RegRWCount*RegDataWidth  CSR RW words.
- csr_reg_set_valid_i  in  1  CSR write-set valid.
- csr_reg_set_ready_o  out  1  CSR write-set ready.
- csr_reg_ro_set_o  out  RegROCount*RegDataWidth  status / perf counter.
- gemm_ctrl_valid_o  out  1  launch request to GEMM.
- gemm_ctrl_ready_i  in  1  GEMM accepts launch.
- gemm_m_o, gemm_k_o, gemm_n_o  out  RegDataWidth each  zero-extended active dims.
- gemm_sub_const_o  out  RegDataWidth  active subtraction constant.
- c_valid_i, c_ready_i  in  1 each  monitored C-output handshake.
- done_o  out  1  one-cycle job-complete pulse.

Behaviour:
- Reset: all state is cleared asynchronously.
  - FSM goes to IDLE; shadow_valid=0; counters=0; sticky bits=0.
  - Outputs at reset: csr_reg_set_ready_o=1; gemm_ctrl_valid_o=0; gemm_*_o=0; done_o=0; ro words=0.
  - Reset mid-job abandons the job without any handshake.
- Shadow register:
  - csr_reg_set_ready_o = ~shadow_valid.
  - On valid&ready: latch words 0-3 (dims truncated to DimWidth) and set shadow_valid at the next edge.
- Zero dimension:
  - If M, K or N is 0 at accept, the job is dropped: shadow stays empty and sticky err_zero (status bit 3) is set.
  - err_zero clears on the next accept with ctrl flag bit0=1.
- FSM states: IDLE, LAUNCH, RUN, DONE.
  - IDLE -> LAUNCH when shadow_valid. In LAUNCH, active regs = shadow and shadow_valid clears on the same edge.
  - Latency: CSR handshake at edge t, shadow_valid at t+1, gemm_ctrl_valid_o high from t+2.
  - LAUNCH: gemm_ctrl_valid_o=1 with active regs on gemm_*_o; outputs stay stable until ready. On gemm_ctrl_ready_i -> RUN and load out_rem = M*N (2*DimWidth bits, never 0).
  - RUN: decrement out_rem on c_valid_i&c_ready_i. A fire with out_rem==1 -> DONE. Non-fire cycles hold.
  - DONE: done_o=1 for exactly one cycle. Next state is LAUNCH if shadow_valid, else IDLE.
- Shadow refill: the shadow may be refilled during LAUNCH (after the copy), RUN or DONE. A new CSR accept in the same cycle as IDLE->LAUNCH is impossible because ready=0.
- gemm_*_o hold the last active job's values outside LAUNCH.
- perf counter (ro[1]):
  - Cleared on entry to LAUNCH; increments every cycle in LAUNCH and RUN.
  - Frozen in DONE/IDLE; saturates at all-ones.
- status (ro[0]):
  - bit0 busy (state!=IDLE).
  - bit1 shadow_valid.
  - bit2 done_seen: sticky, set in DONE, cleared on accept.
  - bit3 err_zero.
  - bit4 timeout (see below).
  - other bits 0.
- Ctrl word 4: bit0 clears sticky bits on accept. Other bits are reserved and ignored.

Optional Feature:
- SNAX_GEMM_CTRL_TIMEOUT_EN defined:
  - A watchdog counts consecutive RUN cycles without a C fire and resets on every fire.
  - Reaching TimeoutCycles forces RUN->DONE, sets sticky status bit4 and still pulses done_o.
- Undefined: no watchdog logic; bit4 reads 0; RUN exits only on the final beat.

Decomposition:
- Package snax_gemm_ctrl_pkg holds:
  - state enum (IDLE, LAUNCH, RUN, DONE);
  - CSR word indices (M, K, N, SUB, CTRL);
  - status bit indices (BUSY, PEND, DONE, ERRZ, TMO);
  - ctrl flag index CLR.
- One sub-module, snax_gemm_ctrl_cnt: loadable, saturating-free down counter with load, dec and is_one outputs. It is used for out_rem, and for the watchdog when enabled.

Test Plan:
- Single job M=2,K=3,N=2: CSR handshake at t -> gemm_ctrl_valid_o at t+2; after launch, exactly 4 C fires -> done_o one cycle; status busy=0, done_seen=1; perf counter = launch-to-last-fire cycles.
- Back-to-back jobs: queue job B (M=1,K=1,N=1) during job A's RUN -> ready_o drops, then re-rises after B launches. DONE goes directly to LAUNCH with B's dims on gemm_*_o. done_o pulses twice.
- Backpressure: gemm_ctrl_ready_i held low 5 cycles -> valid and dims stable for all 5 cycles. C fires throttled with c_ready_i toggling -> only fires decrement; done after exactly M*N fires.
- Zero dim: N=0 written -> no launch; err_zero=1; next accept with ctrl bit0=1 clears it.
- Async reset asserted mid-RUN (out_rem=3) -> immediate IDLE, valid_o=0, ready_o=1, ro words=0, no done_o.
- TIMEOUT_EN, TimeoutCycles=16: launch, no C fires -> DONE after 16 RUN cycles, status bit4=1, done_o pulse.
